hazard_forward_unit: RTL and testbench
======================================

Name: hazard_forward_unit

Overview:
Parametrised forwarding and hazard unit for the 5-stage pipeline, replacing the fixed two-source combinational forwarding logic. It provides per-source forward selects for NUM_SRC EX-stage operands and blocks EX/MEM forwarding of load results. It also detects load-use hazards with a configurable bubble count (LOAD_LAT) through a stall FSM, and freezes the pipeline while data memory is busy. Saturating stall and forward event counters are included for performance debug.

Parameters:
REG_W, 5, register-address width
NUM_SRC, 2, number of source operands per instruction (>=1)
LOAD_LAT, 1, total bubbles inserted per load-use hazard (>=1)
CNT_W, 16, width of performance counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
id_src  in  NUM_SRC*REG_W  source reg addresses of instruction in ID; src i at [i*REG_W +: REG_W]
id_src_valid  in  NUM_SRC  per-source "source is actually read" flag, ID stage
ex_src  in  NUM_SRC*REG_W  source reg addresses of instruction in EX (ID/EX register)
ex_src_valid  in  NUM_SRC  per-source valid, EX stage
ID_EX_MemRead  in  1  instruction in EX is a load
ID_EX_Rd  in  REG_W  destination of instruction in EX
EX_MEM_RegWrite  in  1  EX/MEM writes a register
EX_MEM_MemRead  in  1  EX/MEM instruction is a load
EX_MEM_Rd  in  REG_W  EX/MEM destination
MEM_WB_RegWrite  in  1  MEM/WB writes a register
MEM_WB_Rd  in  REG_W  MEM/WB destination
mem_busy  in  1  data memory not ready; whole pipeline must hold
fwd_sel  out  2*NUM_SRC  per-source select at [2i+1:2i]: 00 regfile, 01 EX/MEM, 10 MEM/WB
pc_write  out  1  PC update enable
if_id_write  out  1  IF/ID write enable
id_ex_bubble  out  1  load NOP into ID/EX
freeze  out  1  hold all pipeline registers
stall_cnt  out  CNT_W  load-use stall cycles, saturating
fwd_cnt  out  CNT_W  cycles with at least one non-zero fwd_sel, saturating

Behaviour:
- Forwarding (combinational) for each src i with ex_src_valid[i]=1:
  - 01 if EX_MEM_RegWrite & !EX_MEM_MemRead & EX_MEM_Rd!=0 & EX_MEM_Rd==ex_src[i].
  - Else 10 if MEM_WB_RegWrite & MEM_WB_Rd!=0 & MEM_WB_Rd==ex_src[i].
  - Else 00.
  - ex_src_valid[i]=0 -> 00. EX/MEM always has priority over MEM/WB.
- Hazard (combinational): hz = ID_EX_MemRead & ID_EX_Rd!=0 & (any i: id_src_valid[i] & id_src[i]==ID_EX_Rd).
- FSM states RUN and LU_STALL; down-counter rem of width clog2(LOAD_LAT+1).
  - RUN, hz=1, mem_busy=0: assert stall this cycle (pc_write=0, if_id_write=0, id_ex_bubble=1). If LOAD_LAT>1, go LU_STALL with rem=LOAD_LAT-1. If LOAD_LAT=1, stay in RUN.
  - LU_STALL: stall asserted and hz ignored. rem decrements each non-frozen cycle. When rem==1, return to RUN next cycle.
  - Total stall cycles per hazard is exactly LOAD_LAT.
- Freeze: mem_busy=1 -> freeze=1, pc_write=0, if_id_write=0, id_ex_bubble=0.
  - FSM state, rem and stall_cnt hold.
  - Freeze dominates the stall outputs.
  - A hazard present during freeze is evaluated in the first cycle after mem_busy falls.
- Not stalled and not frozen: pc_write=1, if_id_write=1, id_ex_bubble=0, freeze=0.
- Counters: stall_cnt +1 each cycle id_ex_bubble=1; fwd_cnt +1 each non-frozen cycle with any fwd_sel!=00. Both saturate at 2^CNT_W-1.
- Reset:
  - rst=1 -> next state RUN, rem=0, both counters 0.
  - While rst=1, outputs are forced to fwd_sel=0, pc_write=1, if_id_write=1, id_ex_bubble=0, freeze=0.
  - Reset during LU_STALL abandons the stall immediately.
- Register 0 never forwards and never causes a hazard.

Test Plan:
- EX/MEM and MEM/WB both write r5, ex_src[0]=5 -> fwd_sel[1:0]=01; drop EX_MEM_RegWrite -> 10; set ex_src_valid[0]=0 -> 00.
- EX_MEM_MemRead=1, EX_MEM_Rd=7 and MEM_WB_Rd=7 both writing, ex_src[1]=7 -> fwd_sel[3:2]=10 (load not forwarded from EX/MEM).
- LOAD_LAT=1: ID_EX_MemRead=1, ID_EX_Rd=3, id_src[0]=3 -> exactly one cycle with pc_write=0, if_id_write=0, id_ex_bubble=1; stall_cnt=1. Same pattern with ID_EX_Rd=0 -> no stall.
- LOAD_LAT=3: hazard -> 3 consecutive stall cycles; mem_busy=1 for 2 cycles mid-stall -> freeze=1, id_ex_bubble=0, stall total still 3, stall_cnt=3.
- rst asserted in 2nd cycle of a LOAD_LAT=3 stall -> next cycle RUN, counters 0, pc_write=1.
- CNT_W=4: 20 forwarding cycles -> fwd_cnt stops at 15.

Source files
------------

// File: rtl/hazard_forward_unit.sv
// Forwarding selects, load-use hazard detection with a LOAD_LAT-bubble stall
// FSM, memory-busy freeze, and saturating stall/forward event counters.
module hazard_forward_unit #(
   parameter int REG_W    = 5,
   parameter int NUM_SRC  = 2,
   parameter int LOAD_LAT = 1,
   parameter int CNT_W    = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_SRC*REG_W-1:0]   id_src,
   input  logic [NUM_SRC-1:0]         id_src_valid,
   input  logic [NUM_SRC*REG_W-1:0]   ex_src,
   input  logic [NUM_SRC-1:0]         ex_src_valid,
   input  logic                       ID_EX_MemRead,
   input  logic [REG_W-1:0]           ID_EX_Rd,
   input  logic                       EX_MEM_RegWrite,
   input  logic                       EX_MEM_MemRead,
   input  logic [REG_W-1:0]           EX_MEM_Rd,
   input  logic                       MEM_WB_RegWrite,
   input  logic [REG_W-1:0]           MEM_WB_Rd,
   input  logic                       mem_busy,
   output logic [2*NUM_SRC-1:0]       fwd_sel,
   output logic                       pc_write,
   output logic                       if_id_write,
   output logic                       id_ex_bubble,
   output logic                       freeze,
   output logic [CNT_W-1:0]           stall_cnt,
   output logic [CNT_W-1:0]           fwd_cnt
);

   localparam int REM_W = $clog2(LOAD_LAT + 1);

   typedef enum logic {RUN, LU_STALL} state_t;

   state_t             state;
   logic [REM_W-1:0]   rem;
   logic [2*NUM_SRC-1:0] fwd_raw;
   logic               hz;
   logic               stall;
   logic               any_fwd;

   // EX/MEM wins over MEM/WB; a load in EX/MEM has no data yet, so it never forwards.
   always_comb begin
      fwd_raw = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (ex_src_valid[i]) begin
            if (EX_MEM_RegWrite && !EX_MEM_MemRead && (EX_MEM_Rd != '0) &&
                (EX_MEM_Rd == ex_src[i*REG_W +: REG_W]))
               fwd_raw[2*i +: 2] = 2'b01;
            else if (MEM_WB_RegWrite && (MEM_WB_Rd != '0) &&
                     (MEM_WB_Rd == ex_src[i*REG_W +: REG_W]))
               fwd_raw[2*i +: 2] = 2'b10;
         end
      end
   end

   always_comb begin
      hz = 1'b0;
      if (ID_EX_MemRead && (ID_EX_Rd != '0)) begin
         for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (id_src_valid[i] && (id_src[i*REG_W +: REG_W] == ID_EX_Rd))
               hz = 1'b1;
         end
      end
   end

   // The first bubble comes from RUN seeing hz; LU_STALL supplies the remaining LOAD_LAT-1.
   assign stall   = (state == LU_STALL) || hz;
   assign any_fwd = |fwd_raw;

   assign fwd_sel      = rst ? '0 : fwd_raw;
   assign freeze       = !rst && mem_busy;
   assign id_ex_bubble = !rst && !mem_busy && stall;
   assign pc_write     = rst || (!mem_busy && !stall);
   assign if_id_write  = rst || (!mem_busy && !stall);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RUN;
         rem       <= '0;
         stall_cnt <= '0;
         fwd_cnt   <= '0;
      end else if (!mem_busy) begin
         case (state)
            RUN: begin
               if (hz && (LOAD_LAT > 1)) begin
                  state <= LU_STALL;
                  rem   <= REM_W'(LOAD_LAT - 1);
               end
            end
            LU_STALL: begin
               rem <= rem - 1'b1;
               if (rem == REM_W'(1))
                  state <= RUN;
            end
            default: state <= RUN;
         endcase
         if (id_ex_bubble && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
         if (any_fwd && (fwd_cnt != '1))
            fwd_cnt <= fwd_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: three instances (LOAD_LAT 1/3/2, CNT_W 16/16/4)
// share stimulus; each is compared against a cycle-level behavioural model.
module tb_hazard_forward_unit;

   localparam int RW = 5;
   localparam int NS = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst;
   logic [NS*RW-1:0] id_src, ex_src;
   logic [NS-1:0]   id_src_valid, ex_src_valid;
   logic            id_ex_memread;
   logic [RW-1:0]   id_ex_rd;
   logic            exmem_rw, exmem_mr;
   logic [RW-1:0]   exmem_rd;
   logic            memwb_rw;
   logic [RW-1:0]   memwb_rd;
   logic            mem_busy;

   logic [2*NS-1:0] fs0, fs1, fs2;
   logic [2:0]      pcw, ifw, bub, frz;
   logic [15:0]     sc0, fc0, sc1, fc1;
   logic [3:0]      sc2, fc2;

   hazard_forward_unit #(.REG_W(RW), .NUM_SRC(NS), .LOAD_LAT(1), .CNT_W(16)) u_l1 (
      .clk(clk), .rst(rst), .id_src(id_src), .id_src_valid(id_src_valid),
      .ex_src(ex_src), .ex_src_valid(ex_src_valid), .ID_EX_MemRead(id_ex_memread),
      .ID_EX_Rd(id_ex_rd), .EX_MEM_RegWrite(exmem_rw), .EX_MEM_MemRead(exmem_mr),
      .EX_MEM_Rd(exmem_rd), .MEM_WB_RegWrite(memwb_rw), .MEM_WB_Rd(memwb_rd),
      .mem_busy(mem_busy), .fwd_sel(fs0), .pc_write(pcw[0]), .if_id_write(ifw[0]),
      .id_ex_bubble(bub[0]), .freeze(frz[0]), .stall_cnt(sc0), .fwd_cnt(fc0));

   hazard_forward_unit #(.REG_W(RW), .NUM_SRC(NS), .LOAD_LAT(3), .CNT_W(16)) u_l3 (
      .clk(clk), .rst(rst), .id_src(id_src), .id_src_valid(id_src_valid),
      .ex_src(ex_src), .ex_src_valid(ex_src_valid), .ID_EX_MemRead(id_ex_memread),
      .ID_EX_Rd(id_ex_rd), .EX_MEM_RegWrite(exmem_rw), .EX_MEM_MemRead(exmem_mr),
      .EX_MEM_Rd(exmem_rd), .MEM_WB_RegWrite(memwb_rw), .MEM_WB_Rd(memwb_rd),
      .mem_busy(mem_busy), .fwd_sel(fs1), .pc_write(pcw[1]), .if_id_write(ifw[1]),
      .id_ex_bubble(bub[1]), .freeze(frz[1]), .stall_cnt(sc1), .fwd_cnt(fc1));

   hazard_forward_unit #(.REG_W(RW), .NUM_SRC(NS), .LOAD_LAT(2), .CNT_W(4)) u_c4 (
      .clk(clk), .rst(rst), .id_src(id_src), .id_src_valid(id_src_valid),
      .ex_src(ex_src), .ex_src_valid(ex_src_valid), .ID_EX_MemRead(id_ex_memread),
      .ID_EX_Rd(id_ex_rd), .EX_MEM_RegWrite(exmem_rw), .EX_MEM_MemRead(exmem_mr),
      .EX_MEM_Rd(exmem_rd), .MEM_WB_RegWrite(memwb_rw), .MEM_WB_Rd(memwb_rd),
      .mem_busy(mem_busy), .fwd_sel(fs2), .pc_write(pcw[2]), .if_id_write(ifw[2]),
      .id_ex_bubble(bub[2]), .freeze(frz[2]), .stall_cnt(sc2), .fwd_cnt(fc2));

   int lat[3]  = '{1, 3, 2};
   int cmax[3] = '{65535, 65535, 15};
   int stall_left[3];
   int sc_m[3];
   int fc_m[3];
   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] fwd_ref(input int i);
      logic [RW-1:0] s;
      s = ex_src[i*RW +: RW];
      if (!ex_src_valid[i]) return 2'b00;
      if (exmem_rw && !exmem_mr && exmem_rd != 0 && exmem_rd == s) return 2'b01;
      if (memwb_rw && memwb_rd != 0 && memwb_rd == s) return 2'b10;
      return 2'b00;
   endfunction

   function automatic logic hz_ref();
      if (!id_ex_memread || id_ex_rd == 0) return 1'b0;
      for (int i = 0; i < NS; i++)
         if (id_src_valid[i] && id_src[i*RW +: RW] == id_ex_rd) return 1'b1;
      return 1'b0;
   endfunction

   // Checks every instance against the model mid-cycle, then advances the model.
   task automatic cycle();
      logic [2*NS-1:0] efs;
      logic h;
      @(negedge clk);
      h   = hz_ref();
      efs = {fwd_ref(1), fwd_ref(0)};
      for (int d = 0; d < 3; d++) begin
         logic [2*NS-1:0] ofs;
         logic [31:0] osc, ofc;
         logic e_pc, e_bub, e_frz, st;
         case (d)
            0: begin ofs = fs0; osc = 32'(sc0); ofc = 32'(fc0); end
            1: begin ofs = fs1; osc = 32'(sc1); ofc = 32'(fc1); end
            default: begin ofs = fs2; osc = 32'(sc2); ofc = 32'(fc2); end
         endcase
         st = 1'b0;
         if (rst) begin
            e_pc = 1'b1; e_bub = 1'b0; e_frz = 1'b0;
         end else if (mem_busy) begin
            e_pc = 1'b0; e_bub = 1'b0; e_frz = 1'b1;
         end else begin
            st = (stall_left[d] > 0) || h;
            e_pc = !st; e_bub = st; e_frz = 1'b0;
         end
         check($sformatf("d%0d fwd_sel", d), 32'(ofs), rst ? 32'd0 : 32'(efs));
         check($sformatf("d%0d pc_write", d), 32'(pcw[d]), 32'(e_pc));
         check($sformatf("d%0d if_id_write", d), 32'(ifw[d]), 32'(e_pc));
         check($sformatf("d%0d id_ex_bubble", d), 32'(bub[d]), 32'(e_bub));
         check($sformatf("d%0d freeze", d), 32'(frz[d]), 32'(e_frz));
         check($sformatf("d%0d stall_cnt", d), osc, 32'(sc_m[d]));
         check($sformatf("d%0d fwd_cnt", d), ofc, 32'(fc_m[d]));
         if (rst) begin
            stall_left[d] = 0; sc_m[d] = 0; fc_m[d] = 0;
         end else if (!mem_busy) begin
            if (st && sc_m[d] < cmax[d]) sc_m[d]++;
            if (efs != 0 && fc_m[d] < cmax[d]) fc_m[d]++;
            if (stall_left[d] > 0) stall_left[d]--;
            else if (h) stall_left[d] = lat[d] - 1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      id_src = '0; id_src_valid = '0; ex_src = '0; ex_src_valid = '0;
      id_ex_memread = 0; id_ex_rd = '0; exmem_rw = 0; exmem_mr = 0; exmem_rd = '0;
      memwb_rw = 0; memwb_rd = '0; mem_busy = 0;
   endtask

   initial begin
      for (int d = 0; d < 3; d++) begin stall_left[d] = 0; sc_m[d] = 0; fc_m[d] = 0; end
      clear_inputs();
      rst = 1;
      @(posedge clk); #1;
      cycle();
      rst = 0;

      // EX/MEM vs MEM/WB priority, then fallback, then invalid source
      exmem_rw = 1; exmem_rd = 5; memwb_rw = 1; memwb_rd = 5;
      ex_src[4:0] = 5; ex_src_valid = 2'b01;
      #1 check("exmem priority", 32'(fs0[1:0]), 32'd1);
      cycle();
      exmem_rw = 0;
      #1 check("memwb fallback", 32'(fs0[1:0]), 32'd2);
      cycle();
      ex_src_valid = 2'b00;
      #1 check("src invalid", 32'(fs0[1:0]), 32'd0);
      cycle();

      // load in EX/MEM must not forward
      clear_inputs();
      exmem_rw = 1; exmem_mr = 1; exmem_rd = 7; memwb_rw = 1; memwb_rd = 7;
      ex_src[9:5] = 7; ex_src_valid = 2'b10;
      #1 check("load not fwd", 32'(fs0[3:2]), 32'd2);
      cycle();
      clear_inputs();

      // load-use hazard, seen for one cycle
      id_ex_memread = 1; id_ex_rd = 3; id_src[4:0] = 3; id_src_valid = 2'b01;
      cycle();
      clear_inputs();
      repeat (4) cycle();
      check("lat1 stall_cnt", 32'(sc0), 32'd1);
      check("lat3 stall_cnt", 32'(sc1), 32'd3);
      check("lat2 stall_cnt", 32'(sc2), 32'd2);

      // r0 destination never stalls
      id_ex_memread = 1; id_ex_rd = 0; id_src_valid = 2'b01;
      #1 check("r0 no stall", 32'(pcw), 32'd7);
      cycle();
      clear_inputs();

      // freeze for two cycles in the middle of a stall
      id_ex_memread = 1; id_ex_rd = 3; id_src[4:0] = 3; id_src_valid = 2'b01;
      cycle();
      clear_inputs();
      mem_busy = 1;
      #1 check("freeze lat3", 32'(frz[1]), 32'd1);
      check("frozen bubble", 32'(bub[1]), 32'd0);
      cycle();
      cycle();
      mem_busy = 0;
      repeat (4) cycle();
      check("lat3 stall after freeze", 32'(sc1), 32'd6);

      // reset in the second stall cycle abandons the stall
      id_ex_memread = 1; id_ex_rd = 3; id_src[4:0] = 3; id_src_valid = 2'b01;
      cycle();
      clear_inputs();
      rst = 1;
      cycle();
      rst = 0;
      #1 check("post-reset pc_write", 32'(pcw), 32'd7);
      check("post-reset stall_cnt", 32'(sc1), 32'd0);
      check("post-reset fwd_cnt", 32'(fc1), 32'd0);
      cycle();

      // 20 forwarding cycles: the 4-bit counter saturates
      exmem_rw = 1; exmem_rd = 5; ex_src[4:0] = 5; ex_src_valid = 2'b01;
      repeat (20) cycle();
      check("fwd_cnt sat", 32'(fc2), 32'd15);
      check("fwd_cnt wide", 32'(fc0), 32'd20);
      clear_inputs();

      // random traffic on a small register range to provoke matches
      repeat (400) begin
         rst           = ($urandom_range(0, 29) == 0);
         mem_busy      = ($urandom_range(0, 4) == 0);
         id_src        = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
         ex_src        = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
         id_src_valid  = 2'($urandom);
         ex_src_valid  = 2'($urandom);
         id_ex_memread = 1'($urandom);
         id_ex_rd      = 5'($urandom_range(0, 3));
         exmem_rw      = 1'($urandom);
         exmem_mr      = ($urandom_range(0, 3) == 0);
         exmem_rd      = 5'($urandom_range(0, 3));
         memwb_rw      = 1'($urandom);
         memwb_rd      = 5'($urandom_range(0, 3));
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
